pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central pipeline sequencer. It owns the per-stage stall and flush controls that drive every inter-stage pipeline register, including EX/MEM, which receives stall[4] and flush. Stall requests come from the IF, ID, EX and MEM stages, and exceptions or ERTN come from the MEM stage. From these the block produces a prioritised stall vector, a flush pulse and a redirect PC, runs a post-flush drain FSM, and keeps exception and stall-watchdog counters.

Parameters:
DRAIN_CYCLES, 2, cycles spent in DRAIN after a flush, during which a new exception is not accepted (range 1..15).
TIMEOUT, 1024, number of consecutive stall cycles that sets stall_timeout.
CNT_W, 16, width of the exception counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
stallreq_if  in  1  stall request from IF.
stallreq_id  in  1  stall request from ID.
stallreq_ex  in  1  stall request from EX.
stallreq_mem  in  1  stall request from MEM.
mem_inst_valid  in  1  MEM stage holds a valid instruction.
mem_excepttype  in  2  00 none, 01 syscall, 10 break, 11 ertn.
mem_current_inst_address  in  32  PC of the MEM-stage instruction.
csr_eentry  in  32  exception entry address.
csr_era  in  32  exception return address.
stall  out  6  bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = hold.
flush  out  1  clears all pipeline registers.
new_pc  out  32  redirect target; valid only while flush=1.
except_commit  out  1  one-cycle pulse to the CSR unit (latch ERA/ESTAT).
except_epc  out  32  PC to write to ERA; valid with except_commit.
except_count  out  CNT_W  number of committed exceptions and ERTNs.
stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, drain_cnt=0, stall_run=0, except_count=0, stall_timeout=0. The outputs stall=6'b0, flush=0, new_pc=0, except_commit=0 and except_epc=0 follow from this state.
- except_hit = (state==RUN) & mem_inst_valid & (mem_excepttype!=00).
- Stall vector is combinational. The highest requesting stage wins:
  - stallreq_mem gives 011111.
  - else stallreq_ex gives 001111.
  - else stallreq_id gives 000111.
  - else stallreq_if gives 000011.
  - else 000000.
  - wb is never stalled.
- Exception beats stall: when except_hit=1, stall=000000 and flush=1 in the same cycle. The EX/MEM and other registers therefore clear at that edge, and the MEM instruction does not commit its register write.
- new_pc (combinational, only while flush=1): csr_era when type is 11, otherwise csr_eentry.
- except_commit = except_hit. except_epc = mem_current_inst_address.
- FSM, two states:
  - RUN: on except_hit, go to DRAIN and load drain_cnt = DRAIN_CYCLES-1.
  - DRAIN: flush=0; the stall vector still follows requests; mem_excepttype is ignored. drain_cnt decrements each cycle and returns to RUN on the edge where it is 0.
  - Consequence: DRAIN_CYCLES=1 means exactly one ignored cycle.
- except_count: increments on each except_hit edge and saturates at all-ones.
- Watchdog:
  - stall_run is 11 bits (enough for TIMEOUT up to 2047). It increments while stall[0]=1 and clears when stall[0]=0.
  - When stall_run reaches TIMEOUT-1 with stall still asserted, stall_timeout is set on that edge.
  - stall_timeout stays at 1 until reset.
  - stall_run saturates; it does not wrap.
- Simultaneous events:
  - Exception plus any stallreq in RUN: the exception wins; the stall requests are dropped for that cycle.
  - A requester that still needs to stall must hold its request into the next cycle.
- Reset mid-DRAIN returns to RUN immediately, with no flush.

Decomposition:
- Shared defines file gets:
  - the excepttype encodings: EXC_NONE, EXC_SYSCALL, EXC_BREAK, EXC_ERTN;
  - the stall vector bit indices: STALL_PC..STALL_WB;
  - the two FSM state codes.
- The watchdog is the one natural sub-module, stall_watchdog (counter plus sticky flag, parameter TIMEOUT).
- Everything else stays flat.

Test Plan:
1. Reset release with no requests -> stall=000000, flush=0, except_count=0 across 10 cycles.
2. stallreq_id=1 and stallreq_mem=1 together for 3 cycles -> stall=011111 for all 3 cycles; after release, stall=000000 on the next cycle.
3. mem_inst_valid=1, type=01, PC=0x1c000040, eentry=0x1c008000 -> same cycle: flush=1, new_pc=0x1c008000, except_commit=1, except_epc=0x1c000040. Next cycle flush=0 and except_count=1.
4. Type 11 with era=0x1c000044 while stallreq_ex=1 -> flush=1, new_pc=0x1c000044, stall=000000.
5. With DRAIN_CYCLES=2: an exception followed by type=10 on the next 2 cycles -> no flush in either cycle. Type=10 on the 3rd cycle -> flush=1.
6. With TIMEOUT=8, hold stallreq_if -> stall_timeout rises on the 8th stall edge and stays at 1 after the request drops. Asserting rst=0 mid-DRAIN -> state returns to RUN and stall_timeout clears.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer.
//   - exception type encodings carried by mem_excepttype
//   - bit positions inside the 6-bit stall vector
//   - FSM state type
//   - stall_vec(): prioritised stall vector from the per-stage requests
package pipeline_ctrl_pkg;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_SYSCALL = 2'b01;
    localparam logic [1:0] EXC_BREAK   = 2'b10;
    localparam logic [1:0] EXC_ERTN    = 2'b11;

    localparam int unsigned STALL_PC  = 0;
    localparam int unsigned STALL_IF  = 1;
    localparam int unsigned STALL_ID  = 2;
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;
    localparam int unsigned STALL_W   = 6;

    // Watchdog run-length counter width (covers TIMEOUT up to 2047).
    localparam int unsigned RUN_W = 11;

    typedef enum logic {
        StRun   = 1'b0,
        StDrain = 1'b1
    } state_e;

    // The deepest requesting stage wins; it and every stage upstream of it hold.
    function automatic logic [STALL_W-1:0] stall_vec(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        logic [STALL_W-1:0] v;
        v = '0;
        if (req_mem) begin
            v[STALL_MEM:STALL_PC] = '1;
        end else if (req_ex) begin
            v[STALL_EX:STALL_PC] = '1;
        end else if (req_id) begin
            v[STALL_ID:STALL_PC] = '1;
        end else if (req_if) begin
            v[STALL_IF:STALL_PC] = '1;
        end
        // Writeback always drains so the stalled instruction can retire.
        v[STALL_WB] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bus between the pipeline stages / CSR unit and the pipeline sequencer.
//   master: stage side, drives stall requests, MEM exception info and CSR vectors
//   slave : sequencer side, drives stall, flush, new_pc, exception commit,
//           exception counter and watchdog flag
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        mem_inst_valid;
    logic [1:0]  mem_excepttype;
    logic [31:0] mem_current_inst_address;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;

    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             except_commit;
    logic [31:0]      except_epc;
    logic [CNT_W-1:0] except_count;
    logic             stall_timeout;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output mem_inst_valid, mem_excepttype, mem_current_inst_address,
        output csr_eentry, csr_era,
        input  stall, flush, new_pc, except_commit, except_epc,
        input  except_count, stall_timeout
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  mem_inst_valid, mem_excepttype, mem_current_inst_address,
        input  csr_eentry, csr_era,
        output stall, flush, new_pc, except_commit, except_epc,
        output except_count, stall_timeout
    );
endinterface

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Stall watchdog: counts consecutive cycles with the PC stage held and raises a
// sticky flag once the run reaches TIMEOUT cycles.
//   clk           clock
//   rst           asynchronous active-low reset
//   stall_pc      stall[STALL_PC] of the current cycle
//   stall_timeout sticky flag, cleared only by reset
module pipeline_ctrl_stall_watchdog
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_pc,
    output logic stall_timeout
);

    logic [RUN_W-1:0] stall_run_q, stall_run_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        stall_run_d = stall_run_q;
        timeout_d   = timeout_q;
        if (!stall_pc) begin
            stall_run_d = '0;
        end else begin
            // Saturate instead of wrapping so a very long stall cannot look short.
            if (stall_run_q != '1) begin
                stall_run_d = stall_run_q + 1'b1;
            end
            // This edge is the TIMEOUT-th consecutive stalled edge.
            if (stall_run_q >= RUN_W'(TIMEOUT - 1)) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_run_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            stall_run_q <= stall_run_d;
            timeout_q   <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer.
// Produces the prioritised per-stage stall vector, the flush pulse and redirect
// PC for exceptions/ERTN seen in MEM, runs a post-flush drain window during
// which further exceptions are ignored, counts committed exceptions and
// monitors stall length through a watchdog.
//   clk  clock, all state on the rising edge
//   rst  asynchronous active-low reset
//   bus  slave side of pipeline_ctrl_if (requests in; stall/flush/new_pc,
//        except_commit/except_epc, except_count, stall_timeout out)
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 1024,
    parameter int unsigned CNT_W        = 16
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    logic [3:0]       drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] except_count_q, except_count_d;

    logic               except_hit;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [31:0]        new_pc;
    logic [31:0]        except_epc;
    logic               stall_timeout;

    // Outputs and next state.
    always_comb begin
        state_d        = state_q;
        drain_cnt_d    = drain_cnt_q;
        except_count_d = except_count_q;
        new_pc         = '0;
        except_epc     = '0;

        // Exception type is only honoured in RUN; DRAIN ignores it entirely.
        except_hit = (state_q == StRun) && bus.mem_inst_valid &&
                     (bus.mem_excepttype != EXC_NONE);

        // The exception flushes everything, so stall requests are dropped
        // for that cycle; requesters must re-assert next cycle.
        if (except_hit) begin
            stall = '0;
        end else begin
            stall = stall_vec(bus.stallreq_if, bus.stallreq_id,
                              bus.stallreq_ex, bus.stallreq_mem);
        end
        flush = except_hit;

        if (except_hit) begin
            except_epc = bus.mem_current_inst_address;
            unique case (bus.mem_excepttype)
                EXC_ERTN:                new_pc = bus.csr_era;
                EXC_SYSCALL, EXC_BREAK:  new_pc = bus.csr_eentry;
                default:                 new_pc = '0;
            endcase
            if (except_count_q != '1) begin
                except_count_d = except_count_q + 1'b1;
            end
        end

        unique case (state_q)
            StRun: begin
                if (except_hit) begin
                    state_d     = StDrain;
                    drain_cnt_d = 4'(DRAIN_CYCLES - 1);
                end
            end
            StDrain: begin
                if (drain_cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d     = StRun;
                drain_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StRun;
            drain_cnt_q    <= '0;
            except_count_q <= '0;
        end else begin
            state_q        <= state_d;
            drain_cnt_q    <= drain_cnt_d;
            except_count_q <= except_count_d;
        end
    end

    pipeline_ctrl_stall_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_stall_watchdog (
        .clk          (clk),
        .rst          (rst),
        .stall_pc     (stall[STALL_PC]),
        .stall_timeout(stall_timeout)
    );

    assign bus.stall         = stall;
    assign bus.flush         = flush;
    assign bus.new_pc        = new_pc;
    assign bus.except_commit = except_hit;
    assign bus.except_epc    = except_epc;
    assign bus.except_count  = except_count_q;
    assign bus.stall_timeout = stall_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    localparam int unsigned DRAIN_CYCLES = 2;
    localparam int unsigned TIMEOUT      = 8;
    localparam int unsigned CNT_W        = 16;

    typedef struct packed {
        logic [5:0]       stall;
        logic             flush;
        logic [31:0]      new_pc;
        logic             commit;
        logic [31:0]      epc;
        logic [CNT_W-1:0] count;
        logic             timeout;
    } obs_t;

    logic clk;
    logic rst;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .TIMEOUT     (TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    obs_t sb[$];

    // Reference model state.
    bit m_drain;
    int m_cnt;
    int m_count;
    int m_run;
    bit m_to;

    function automatic obs_t observe();
        return {bus.stall, bus.flush, bus.new_pc, bus.except_commit, bus.except_epc,
                bus.except_count, bus.stall_timeout};
    endfunction

    task automatic model_reset();
        m_drain = 0;
        m_cnt   = 0;
        m_count = 0;
        m_run   = 0;
        m_to    = 0;
    endtask

    // Drive one cycle of stimulus (req = {mem, ex, id, if}), queue the expected
    // outputs for this cycle and advance the model across the coming edge.
    task automatic drive(input logic [3:0] req, input logic valid, input logic [1:0] et,
                         input logic [31:0] pc, input logic [31:0] eentry,
                         input logic [31:0] era);
        obs_t e;
        bit   hit;
        bus.stallreq_mem             = req[3];
        bus.stallreq_ex              = req[2];
        bus.stallreq_id              = req[1];
        bus.stallreq_if              = req[0];
        bus.mem_inst_valid           = valid;
        bus.mem_excepttype           = et;
        bus.mem_current_inst_address = pc;
        bus.csr_eentry               = eentry;
        bus.csr_era                  = era;

        hit = !m_drain && valid && (et != 2'b00);
        e   = '0;
        if (hit)         e.stall = 6'b000000;
        else if (req[3]) e.stall = 6'b011111;
        else if (req[2]) e.stall = 6'b001111;
        else if (req[1]) e.stall = 6'b000111;
        else if (req[0]) e.stall = 6'b000011;
        e.flush   = hit;
        e.new_pc  = hit ? ((et == 2'b11) ? era : eentry) : 32'h0;
        e.commit  = hit;
        e.epc     = hit ? pc : 32'h0;
        e.count   = CNT_W'(m_count);
        e.timeout = m_to;
        sb.push_back(e);

        if (hit) begin
            m_drain = 1;
            m_cnt   = DRAIN_CYCLES - 1;
        end else if (m_drain) begin
            if (m_cnt == 0) m_drain = 0;
            else m_cnt--;
        end
        if (hit && m_count < (2 ** CNT_W) - 1) m_count++;
        if (e.stall[0]) begin
            m_run++;
            if (m_run >= TIMEOUT) m_to = 1;
        end else begin
            m_run = 0;
        end
    endtask

    task automatic idle();
        drive(4'b0000, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        obs_t got, exp;
        rst = 1'b0;
        idle();
        void'(sb.pop_front());
        model_reset();
        #12;
        checks++;
        if (bus.stall !== 6'b0 || bus.flush !== 1'b0 || bus.except_count !== '0 ||
            bus.stall_timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got stall=%b flush=%b count=%0d to=%b exp all zero",
                     bus.stall, bus.flush, bus.except_count, bus.stall_timeout);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            idle();
            @(negedge clk);
            got = observe();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_idle[%0d]: got %h exp %h", i, got, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall_priority();
        obs_t got, exp;
        logic [3:0] pats [6] = '{4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0100, 4'b0011};
        for (int i = 0; i < 6; i++) begin
            drive(pats[i], 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
            @(negedge clk);
            got = observe();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL stall_priority[%0d]: got stall=%b exp stall=%b (full got %h exp %h)",
                         i, got.stall, exp.stall, got, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Exception cases, each followed by idle cycles to leave DRAIN.
    task automatic test_exceptions();
        obs_t got, exp;
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: drive(4'b0000, 1'b1, 2'b01, 32'h1c000040, 32'h1c008000, 32'h0);
                4: drive(4'b0100, 1'b1, 2'b11, 32'h1c000080, 32'h1c008000, 32'h1c000044);
                5: drive(4'b0001, 1'b1, 2'b10, 32'h1c000090, 32'h1c008000, 32'h1c000044);
                default: idle();
            endcase
            @(negedge clk);
            got = observe();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL exception[%0d]: got flush=%b new_pc=%h epc=%h count=%0d exp flush=%b new_pc=%h epc=%h count=%0d",
                         i, got.flush, got.new_pc, got.epc, got.count,
                         exp.flush, exp.new_pc, exp.epc, exp.count);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_drain_window();
        obs_t got, exp;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) drive(4'b0000, 1'b1, 2'b01, 32'h1c000100, 32'h1c008000, 32'h0);
            else if (i <= 3) drive(4'b0000, 1'b1, 2'b10, 32'h1c000104 + i, 32'h1c008000, 32'h0);
            else idle();
            @(negedge clk);
            got = observe();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL drain_window[%0d]: got flush=%b new_pc=%h exp flush=%b new_pc=%h",
                         i, got.flush, got.new_pc, exp.flush, exp.new_pc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_watchdog_and_reset();
        obs_t got, exp;
        for (int i = 0; i < 14; i++) begin
            if (i < 10) drive(4'b0001, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0);
            else if (i == 12) drive(4'b0000, 1'b1, 2'b01, 32'h1c000200, 32'h1c008000, 32'h0);
            else idle();
            @(negedge clk);
            got = observe();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL watchdog[%0d]: got to=%b stall=%b exp to=%b stall=%b",
                         i, got.timeout, got.stall, exp.timeout, exp.stall);
            end
            @(posedge clk);
            #1;
        end
        // Now in DRAIN; reset asynchronously between edges.
        rst = 1'b0;
        #2;
        checks++;
        if (bus.stall_timeout !== 1'b0 || bus.except_count !== '0 || bus.flush !== 1'b0) begin
            failures++;
            $display("FAIL mid_drain_reset: got to=%b count=%0d flush=%b exp 0 0 0",
                     bus.stall_timeout, bus.except_count, bus.flush);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Back in RUN: an exception must be accepted immediately.
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(4'b0000, 1'b1, 2'b11, 32'h1c000300, 32'h1c008000, 32'h1c000304);
            else idle();
            @(negedge clk);
            got = observe();
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL after_reset[%0d]: got %h exp %h", i, got, exp);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stall_priority();
        test_exceptions();
        test_drain_window();
        test_watchdog_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule
